// File: rtl/m_spawn_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// pkg_spawn
// Shared definitions for the spawn scheduler:
//   - state encoding of the scheduler FSM (IDLE/LOAD/COUNT/OFFER)
//   - default widths and timing parameters
//   - cnt_w_fits(): tells whether a gap counter width can hold the largest
//     gap MIN_GAP + 2^GAP_BITS - 1
// ---------------------------------------------------------------------------
package pkg_spawn;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_OFFER = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_COUNT = ST_COUNT,
        S_OFFER = ST_OFFER
    } state_t;

    localparam int DEF_MIN_GAP   = 4;
    localparam int DEF_GAP_BITS  = 8;
    localparam int DEF_LANE_BITS = 2;
    localparam int DEF_CNT_W     = 16;
    localparam int SPAWN_CNT_W   = 16;

    // True when a cnt_w-bit counter can hold min_gap + 2^gap_bits - 1.
    function automatic bit cnt_w_fits(input int cnt_w, input int min_gap, input int gap_bits);
        longint need;
        need = longint'(min_gap) + (64'sd1 <<< gap_bits) - 64'sd1;
        if (cnt_w >= 62) begin
            return 1'b1;
        end else begin
            return (need < (64'sd1 <<< cnt_w));
        end
    endfunction

endpackage

// File: rtl/m_spawn_scheduler_gap_timer.sv
// ---------------------------------------------------------------------------
// m_gap_timer
// Loadable down-counter that times the gap between event load and offer.
// The zero flag is registered alongside the count so it is valid in the same
// cycle the count reaches zero; the counter stops at zero.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   srst           synchronous clear
//   load           load load_value (has priority over en)
//   en             decrement by one when not already zero
//   load_value     value to load
//   value          current count
//   zero           count is zero
// ---------------------------------------------------------------------------
module m_gap_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] value_r;
    logic             zero_r;

    // Counter register with its registered zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= CNT_ZERO;
            zero_r  <= 1'b1;
        end else if (srst) begin
            value_r <= CNT_ZERO;
            zero_r  <= 1'b1;
        end else if (load) begin
            value_r <= load_value;
            zero_r  <= (load_value == CNT_ZERO);
        end else if (en && !zero_r) begin
            value_r <= value_r - CNT_ONE;
            zero_r  <= (value_r == CNT_ONE);
        end else begin
            value_r <= value_r;
            zero_r  <= zero_r;
        end
    end

    assign value = value_r;
    assign zero  = zero_r;

endmodule

// File: rtl/m_spawn_scheduler.sv
// ---------------------------------------------------------------------------
// m_spawn_scheduler
// Turns the free-running 32-bit random stream into randomly timed spawn
// events. Per event: sample one random word (LOAD), count a gap of
// MIN_GAP + (rand[GAP_BITS-1:0] >> w_level) cycles (COUNT), then offer the
// event with its lane and kind on a valid/ready handshake (OFFER).
// Ports:
//   clk          system clock
//   w_rst_n      asynchronous active-low reset
//   w_rand       random word, sampled only in LOAD
//   w_enable     run request
//   w_level      difficulty, right-shift applied to the raw gap
//   w_ready      consumer accepts the offered event
//   o_valid      event offered
//   o_lane       lane of the event (rand[16 +: LANE_BITS])
//   o_kind       kind of the event (rand[31])
//   o_spawn_cnt  accepted-event count, wraps
//   o_busy       high while in LOAD/COUNT/OFFER
// ---------------------------------------------------------------------------
module m_spawn_scheduler
    import pkg_spawn::*;
#(
    parameter int MIN_GAP   = DEF_MIN_GAP,
    parameter int GAP_BITS  = DEF_GAP_BITS,
    parameter int LANE_BITS = DEF_LANE_BITS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   w_rst_n,
    input  logic [31:0]            w_rand,
    input  logic                   w_enable,
    input  logic [2:0]             w_level,
    input  logic                   w_ready,
    output logic                   o_valid,
    output logic [LANE_BITS-1:0]   o_lane,
    output logic                   o_kind,
    output logic [SPAWN_CNT_W-1:0] o_spawn_cnt,
    output logic                   o_busy
);

    state_t                 state_r;
    logic                   valid_r;
    logic [LANE_BITS-1:0]   lane_r;
    logic                   kind_r;
    logic [SPAWN_CNT_W-1:0] spawn_cnt_r;
    logic                   busy_r;

    logic [CNT_W-1:0]       raw_gap_s;
    logic [CNT_W-1:0]       load_value_s;
    logic                   timer_load_s;
    logic                   timer_en_s;
    logic [CNT_W-1:0]       timer_value_s;
    logic                   timer_zero_s;
    logic                   unused_s;

    // Gap computation: zero-extend before shifting, so any level that
    // shifts out every gap bit leaves just MIN_GAP.
    always_comb begin
        raw_gap_s    = CNT_W'(w_rand[GAP_BITS-1:0]) >> w_level;
        load_value_s = CNT_W'(MIN_GAP) + raw_gap_s;
        timer_load_s = (state_r == S_LOAD);
        timer_en_s   = (state_r == S_COUNT) && w_enable;
    end

    m_gap_timer #(
        .CNT_W (CNT_W)
    ) u_gap_timer (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .srst       (1'b0),
        .load       (timer_load_s),
        .en         (timer_en_s),
        .load_value (load_value_s),
        .value      (timer_value_s),
        .zero       (timer_zero_s)
    );

    // Scheduler FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_r     <= S_IDLE;
            valid_r     <= 1'b0;
            lane_r      <= '0;
            kind_r      <= 1'b0;
            spawn_cnt_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    valid_r <= 1'b0;
                    if (w_enable) begin
                        state_r <= S_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    lane_r  <= w_rand[16 +: LANE_BITS];
                    kind_r  <= w_rand[31];
                    state_r <= S_COUNT;
                    busy_r  <= 1'b1;
                end
                S_COUNT: begin
                    // Dropping enable abandons the event before it is offered.
                    if (!w_enable) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else if (timer_zero_s) begin
                        state_r <= S_OFFER;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_COUNT;
                        busy_r  <= 1'b1;
                    end
                end
                S_OFFER: begin
                    // An offered event is never retracted, only accepted.
                    if (w_ready) begin
                        valid_r     <= 1'b0;
                        spawn_cnt_r <= spawn_cnt_r + 16'd1;
                        if (w_enable) begin
                            state_r <= S_LOAD;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= S_OFFER;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid     = valid_r;
    assign o_lane      = lane_r;
    assign o_kind      = kind_r;
    assign o_spawn_cnt = spawn_cnt_r;
    assign o_busy      = busy_r;

    // Random bits that carry no meaning for this block, and the raw count.
    assign unused_s = ^{w_rand[30:16+LANE_BITS], w_rand[15:GAP_BITS], timer_value_s};

endmodule

// File: tb/tb_m_spawn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_m_spawn_scheduler
// Directed bench for m_spawn_scheduler. A deadline-based model predicts the
// outputs every cycle; directed phases add hand-computed latency, lane/kind,
// backpressure, enable-drop, reset and counter-wrap expectations.
// ---------------------------------------------------------------------------
module tb_m_spawn_scheduler;

    logic        clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic [31:0] w_rand = 32'h0;
    logic        w_enable = 1'b0;
    logic [2:0]  w_level = 3'd0;
    logic        w_ready = 1'b0;
    logic        o_valid;
    logic [1:0]  o_lane;
    logic        o_kind;
    logic [15:0] o_spawn_cnt;
    logic        o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int          cyc = 0;
    bit          m_load_next = 1'b0;
    bit          m_pending = 1'b0;
    int          m_offer_at = 0;
    bit          m_valid = 1'b0;
    logic [1:0]  m_lane = 2'd0;
    bit          m_kind = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_busy = 1'b0;

    m_spawn_scheduler dut (
        .clk         (clk),
        .w_rst_n     (w_rst_n),
        .w_rand      (w_rand),
        .w_enable    (w_enable),
        .w_level     (w_level),
        .w_ready     (w_ready),
        .o_valid     (o_valid),
        .o_lane      (o_lane),
        .o_kind      (o_kind),
        .o_spawn_cnt (o_spawn_cnt),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        bit in_load;
        int gap;
        if (!w_rst_n) begin
            m_load_next = 1'b0;
            m_pending   = 1'b0;
            m_valid     = 1'b0;
            m_lane      = 2'd0;
            m_kind      = 1'b0;
            m_cnt       = 16'd0;
            m_busy      = 1'b0;
        end else begin
            in_load     = m_load_next;
            m_load_next = 1'b0;
            if (m_valid) begin
                if (w_ready) begin
                    m_valid     = 1'b0;
                    m_cnt       = m_cnt + 16'd1;
                    m_load_next = w_enable;
                end
            end else if (in_load) begin
                gap        = 4 + (int'(w_rand[7:0]) >> w_level);
                m_lane     = w_rand[17:16];
                m_kind     = w_rand[31];
                m_pending  = 1'b1;
                m_offer_at = cyc + gap + 2;
            end else if (m_pending) begin
                if (!w_enable) begin
                    m_pending = 1'b0;
                end else if (cyc + 1 == m_offer_at) begin
                    m_pending = 1'b0;
                    m_valid   = 1'b1;
                end
            end else if (w_enable) begin
                m_load_next = 1'b1;
            end
            m_busy = m_load_next || m_pending || m_valid;
        end
        cyc++;
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("valid", 32'(o_valid), 32'(m_valid));
            check("lane", 32'(o_lane), 32'(m_lane));
            check("kind", 32'(o_kind), 32'(m_kind));
            check("spawn_cnt", 32'(o_spawn_cnt), 32'(m_cnt));
            check("busy", 32'(o_busy), 32'(m_busy));
        end
    end

    // Count posedges until o_valid is seen high (999 on timeout).
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (o_valid) return;
        end
        n = 999;
    endtask

    // Accept the pending offer with enable low, landing in IDLE.
    task automatic accept_and_idle(input logic [15:0] exp_cnt, input string tag);
        @(negedge clk);
        w_enable = 1'b0;
        w_ready  = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        check({tag, "_cnt"}, 32'(o_spawn_cnt), 32'(exp_cnt));
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        @(negedge clk);
        w_ready = 1'b0;
    endtask

    initial begin
        int n;
        int nv;

        // reset
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_cnt", 32'(o_spawn_cnt), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        w_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic offer: G=9 -> 12 edges from enable to valid
        w_rand   = 32'h8003_0005;
        w_level  = 3'd0;
        w_enable = 1'b1;
        wait_valid(n);
        check("basic_latency", 32'(n), 32'd12);
        check("basic_lane", 32'(o_lane), 32'd3);
        check("basic_kind", 32'(o_kind), 32'd1);

        // backpressure with enable dropped and rand changing
        @(negedge clk);
        w_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_rand = $urandom;
            @(negedge clk);
        end
        check("bp_valid", 32'(o_valid), 32'd1);
        check("bp_lane", 32'(o_lane), 32'd3);
        check("bp_kind", 32'(o_kind), 32'd1);
        check("bp_cnt", 32'(o_spawn_cnt), 32'd0);
        accept_and_idle(16'd1, "bp");
        repeat (2) @(negedge clk);
        check("bp_cnt_once", 32'(o_spawn_cnt), 32'd1);

        // level shift: 0xFF >> 2 = 63 -> G=67
        w_rand   = 32'h0000_00FF;
        w_level  = 3'd2;
        w_enable = 1'b1;
        wait_valid(n);
        check("lvl2_latency", 32'(n), 32'd70);
        check("lvl2_lane", 32'(o_lane), 32'd0);
        accept_and_idle(16'd2, "lvl2");

        // level 7: 0x7F >> 7 = 0 -> G=4
        @(negedge clk);
        w_rand   = 32'h7FFF_FF7F;
        w_level  = 3'd7;
        w_enable = 1'b1;
        wait_valid(n);
        check("lvl7_latency", 32'(n), 32'd7);
        check("lvl7_lane", 32'(o_lane), 32'd3);
        check("lvl7_kind", 32'(o_kind), 32'd0);
        accept_and_idle(16'd3, "lvl7");

        // enable drop during COUNT: no event
        @(negedge clk);
        w_rand   = 32'h0000_0010;
        w_level  = 3'd0;
        w_enable = 1'b1;
        repeat (8) @(negedge clk);
        w_enable = 1'b0;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_valid) nv++;
        end
        check("drop_no_valid", 32'(nv), 32'd0);
        check("drop_busy", 32'(o_busy), 32'd0);

        // asynchronous reset mid-COUNT
        w_rand   = 32'h8002_0040;
        w_enable = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_rst_lane", 32'(o_lane), 32'd2);
        w_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_lane", 32'(o_lane), 32'd0);
        check("arst_kind", 32'(o_kind), 32'd0);
        check("arst_cnt", 32'(o_spawn_cnt), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        w_enable = 1'b0;
        repeat (2) @(negedge clk);
        w_rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_valid || o_busy) nv++;
        end
        check("post_rst_quiet", 32'(nv), 32'd0);

        // streaming with counter wrap
        force dut.spawn_cnt_r = 16'hFFFD;
        m_cnt = 16'hFFFD;
        #1;
        release dut.spawn_cnt_r;
        @(negedge clk);
        w_rand   = 32'h0000_0000;
        w_level  = 3'd0;
        w_ready  = 1'b1;
        w_enable = 1'b1;
        wait_valid(n);
        check("stream_first", 32'(n), 32'd7);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!o_valid && n < 50);
            check("stream_period", 32'(n), 32'd7);
        end
        @(negedge clk);
        w_enable = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_cnt", 32'(o_spawn_cnt), 32'h0001);
        check("wrap_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        w_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
